// File: rtl/circuit_hlsm_pkg.sv
// rtl/circuit_hlsm_pkg.sv - shared state encoding and ALU mode constants for circuit_hlsm
package circuit_hlsm_pkg;

    // Schedule: latch operands, three passes through the shared add/sub unit,
    // select, shift, then a one-cycle completion strobe.
    typedef enum logic [2:0] {
        ST_WAIT  = 3'd0,
        ST_S1    = 3'd1,
        ST_S2    = 3'd2,
        ST_S3    = 3'd3,
        ST_S4    = 3'd4,
        ST_S5    = 3'd5,
        ST_FINAL = 3'd6
    } state_e;

    localparam logic ALU_ADD = 1'b0;
    localparam logic ALU_SUB = 1'b1;

endpackage

// File: rtl/circuit_hlsm_alu.sv
// rtl/circuit_hlsm_alu.sv - shared add/sub, lt/eq comparator and 1-bit shifters
module circuit_hlsm_alu
    import circuit_hlsm_pkg::*;
#(
    parameter int DATAWIDTH = 32,
    parameter bit SIGNED    = 1'b1
) (
    input  logic                 mode_i,
    input  logic [DATAWIDTH-1:0] op_a_i,
    input  logic [DATAWIDTH-1:0] op_b_i,
    input  logic [DATAWIDTH-1:0] cmp_a_i,
    input  logic [DATAWIDTH-1:0] cmp_b_i,
    input  logic [DATAWIDTH-1:0] shl_i,
    input  logic                 shl_amt_i,
    input  logic [DATAWIDTH-1:0] shr_i,
    input  logic                 shr_amt_i,
    output logic [DATAWIDTH-1:0] sum_o,
    output logic                 lt_o,
    output logic                 eq_o,
    output logic [DATAWIDTH-1:0] shl_o,
    output logic [DATAWIDTH-1:0] shr_o
);

    logic [DATAWIDTH-1:0] b_eff;
    logic                 carry_in;

    // Subtraction is a + ~b + 1 so one adder serves both modes; wraps freely.
    assign carry_in = (mode_i == ALU_SUB);
    assign b_eff    = carry_in ? ~op_b_i : op_b_i;
    assign sum_o    = op_a_i + b_eff + DATAWIDTH'(carry_in);

    assign eq_o  = (cmp_a_i == cmp_b_i);
    // Left shift by one drops the MSB.
    assign shl_o = shl_amt_i ? {shl_i[DATAWIDTH-2:0], 1'b0} : shl_i;

    // Signedness lives in separate branches so the arithmetic shift is never
    // turned logical by an unsigned context.
    if (SIGNED) begin : g_signed
        logic signed [DATAWIDTH-1:0] shr_s;
        assign shr_s = $signed(shr_i) >>> 1;
        assign lt_o  = ($signed(cmp_a_i) < $signed(cmp_b_i));
        assign shr_o = shr_amt_i ? shr_s : shr_i;
    end else begin : g_unsigned
        assign lt_o  = (cmp_a_i < cmp_b_i);
        assign shr_o = shr_amt_i ? (shr_i >> 1) : shr_i;
    end

endmodule

// File: rtl/circuit_hlsm.sv
// rtl/circuit_hlsm.sv - scheduled compare/mux/shift datapath with Start/Done handshake
module circuit_hlsm
    import circuit_hlsm_pkg::*;
#(
    parameter int DATAWIDTH = 32,
    parameter bit SIGNED    = 1'b1
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 Start,
    input  logic [DATAWIDTH-1:0] a,
    input  logic [DATAWIDTH-1:0] b,
    input  logic [DATAWIDTH-1:0] c,
    output logic                 Busy,
    output logic                 Done,
    output logic [DATAWIDTH-1:0] x,
    output logic [DATAWIDTH-1:0] z
);

    state_e               state_q, state_d;
    logic [DATAWIDTH-1:0] ra_q, rb_q, rc_q;
    logic [DATAWIDTH-1:0] d_q, e_q, f_q, g_q, h_q;
    logic                 lt_q, eq_q;
    logic [DATAWIDTH-1:0] x_q, z_q;

    logic                 alu_mode;
    logic [DATAWIDTH-1:0] alu_b, alu_sum, shl_out, shr_out, g_mux;
    logic                 alu_lt, alu_eq;

    // Operand steering for the shared unit: S2 adds c, S3 subtracts b, else adds b.
    always_comb begin
        alu_mode = ALU_ADD;
        alu_b    = rb_q;
        if (state_q == ST_S2) begin
            alu_b = rc_q;
        end
        if (state_q == ST_S3) begin
            alu_mode = ALU_SUB;
        end
    end

    circuit_hlsm_alu #(
        .DATAWIDTH (DATAWIDTH),
        .SIGNED    (SIGNED)
    ) u_alu (
        .mode_i    (alu_mode),
        .op_a_i    (ra_q),
        .op_b_i    (alu_b),
        .cmp_a_i   (d_q),
        .cmp_b_i   (e_q),
        .shl_i     (g_q),
        .shl_amt_i (lt_q),
        .shr_i     (h_q),
        .shr_amt_i (eq_q),
        .sum_o     (alu_sum),
        .lt_o      (alu_lt),
        .eq_o      (alu_eq),
        .shl_o     (shl_out),
        .shr_o     (shr_out)
    );

    // h takes this cycle's g selection, not the previous g register.
    assign g_mux = lt_q ? e_q : d_q;

    // Next-state sequencing; Start only matters while idle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_WAIT:  if (Start) state_d = ST_S1;
            ST_S1:    state_d = ST_S2;
            ST_S2:    state_d = ST_S3;
            ST_S3:    state_d = ST_S4;
            ST_S4:    state_d = ST_S5;
            ST_S5:    state_d = ST_FINAL;
            ST_FINAL: state_d = ST_WAIT;
            default:  state_d = ST_WAIT;
        endcase
    end

    // State, operand, intermediate and result registers; reset clears everything.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q <= ST_WAIT;
            ra_q    <= '0;
            rb_q    <= '0;
            rc_q    <= '0;
            d_q     <= '0;
            e_q     <= '0;
            f_q     <= '0;
            g_q     <= '0;
            h_q     <= '0;
            lt_q    <= 1'b0;
            eq_q    <= 1'b0;
            x_q     <= '0;
            z_q     <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_WAIT: begin
                    if (Start) begin
                        ra_q <= a;
                        rb_q <= b;
                        rc_q <= c;
                    end
                end
                ST_S1: d_q <= alu_sum;
                ST_S2: e_q <= alu_sum;
                ST_S3: begin
                    f_q  <= alu_sum;
                    lt_q <= alu_lt;
                    eq_q <= alu_eq;
                end
                ST_S4: begin
                    g_q <= g_mux;
                    h_q <= eq_q ? f_q : g_mux;
                end
                ST_S5: begin
                    x_q <= shl_out;
                    z_q <= shr_out;
                end
                default: ;
            endcase
        end
    end

    assign Busy = (state_q != ST_WAIT);
    assign Done = (state_q == ST_FINAL);
    assign x    = x_q;
    assign z    = z_q;

endmodule

// File: tb/tb_circuit_hlsm.sv
// tb/tb_circuit_hlsm.sv - randomized and directed self-checking bench for circuit_hlsm
module tb_circuit_hlsm;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] a32, b32, c32;
    logic [7:0]  a8, b8, c8;

    logic        busy32, done32, busy8u, done8u, busy8s, done8s;
    logic [31:0] x32, z32;
    logic [7:0]  x8u, z8u, x8s, z8s;

    int n_vec  = 0;
    int n_fail = 0;

    circuit_hlsm #(.DATAWIDTH(32), .SIGNED(1'b1)) dut32 (
        .Clk(clk), .Rst(rst_n), .Start(start), .a(a32), .b(b32), .c(c32),
        .Busy(busy32), .Done(done32), .x(x32), .z(z32)
    );
    circuit_hlsm #(.DATAWIDTH(8), .SIGNED(1'b0)) dut8u (
        .Clk(clk), .Rst(rst_n), .Start(start), .a(a8), .b(b8), .c(c8),
        .Busy(busy8u), .Done(done8u), .x(x8u), .z(z8u)
    );
    circuit_hlsm #(.DATAWIDTH(8), .SIGNED(1'b1)) dut8s (
        .Clk(clk), .Rst(rst_n), .Start(start), .a(a8), .b(b8), .c(c8),
        .Busy(busy8s), .Done(done8s), .x(x8s), .z(z8s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic longint to_val(input longint v, input int w, input bit sg);
        if (sg && v[w-1]) return v - (longint'(1) << w);
        return v;
    endfunction

    // Reference: evaluate the dataflow equations directly with wide integers.
    function automatic void model(input longint a, input longint b, input longint c,
                                  input int w, input bit sg,
                                  output longint xo, output longint zo);
        longint mask, d, e, f, g, h;
        bit lt, eq;
        mask = (longint'(1) << w) - 1;
        d  = (a + b) & mask;
        e  = (a + c) & mask;
        f  = (a - b) & mask;
        lt = to_val(d, w, sg) < to_val(e, w, sg);
        eq = (d == e);
        g  = lt ? e : d;
        h  = eq ? f : g;
        xo = (lt ? g * 2 : g) & mask;
        if (!eq)     zo = h;
        else if (sg) zo = (to_val(h, w, sg) >>> 1) & mask;
        else         zo = h / 2;
    endfunction

    // One operation on all three instances; optional second Start while busy.
    task automatic run_op(input logic [31:0] ia, input logic [31:0] ib, input logic [31:0] ic,
                          input logic [7:0] ja, input logic [7:0] jb, input logic [7:0] jc,
                          input bit retrig, input string tag);
        longint ex, ez;
        int busy_cnt, done_cnt, done_at;
        busy_cnt = 0; done_cnt = 0; done_at = -1;
        @(negedge clk);
        a32 = ia; b32 = ib; c32 = ic; a8 = ja; b8 = jb; c8 = jc;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a32 = $urandom; b32 = $urandom; c32 = $urandom;
        a8 = 8'($urandom); b8 = 8'($urandom); c8 = 8'($urandom);
        if (busy32) busy_cnt++;
        if (done32) begin done_cnt++; done_at = 1; end
        for (int idx = 2; idx <= 13; idx++) begin
            if (retrig && idx == 4) begin
                start = 1'b1;
                a32 = $urandom; b32 = $urandom; c32 = $urandom;
                a8 = 8'($urandom); b8 = 8'($urandom); c8 = 8'($urandom);
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            if (busy32) busy_cnt++;
            if (done32) begin
                done_cnt++;
                if (done_at < 0) done_at = idx;
            end
        end
        chk({tag, ".done_edge"}, 64'(done_at), 64'd6);
        chk({tag, ".done_count"}, 64'(done_cnt), 64'd1);
        chk({tag, ".busy_cycles"}, 64'(busy_cnt), 64'd6);
        model(longint'(ia), longint'(ib), longint'(ic), 32, 1'b1, ex, ez);
        chk({tag, ".x32"}, 64'(x32), ex);
        chk({tag, ".z32"}, 64'(z32), ez);
        model(longint'(ja), longint'(jb), longint'(jc), 8, 1'b0, ex, ez);
        chk({tag, ".x8u"}, 64'(x8u), ex);
        chk({tag, ".z8u"}, 64'(z8u), ez);
        model(longint'(ja), longint'(jb), longint'(jc), 8, 1'b1, ex, ez);
        chk({tag, ".x8s"}, 64'(x8s), ex);
        chk({tag, ".z8s"}, 64'(z8s), ez);
    endtask

    initial begin
        int dones;
        logic [31:0] ra, rb, rc;
        rst_n = 1'b0;
        start = 1'b0;
        a32 = '0; b32 = '0; c32 = '0; a8 = '0; b8 = '0; c8 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.busy", 64'(busy32), 64'd0);
        chk("reset.done", 64'(done32), 64'd0);
        chk("reset.x", 64'(x32), 64'd0);
        chk("reset.z", 64'(z32), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases with hand-derived constants.
        run_op(32'd5, 32'd3, 32'd10, 8'd5, 8'd3, 8'd10, 1'b0, "basic");
        chk("basic.x_const", 64'(x32), 64'd30);
        chk("basic.z_const", 64'(z32), 64'd15);
        run_op(32'd4, 32'd2, 32'd2, 8'd4, 8'd2, 8'd2, 1'b0, "equal");
        chk("equal.x_const", 64'(x32), 64'd6);
        chk("equal.z_const", 64'(z32), 64'd1);
        run_op(-32'sd7, 32'd0, 32'd0, 8'hF9, 8'd0, 8'd0, 1'b0, "neg7");
        chk("neg7.x_const", 64'(x32), 64'(32'hFFFF_FFF9));
        chk("neg7.z_const", 64'(z32), 64'(32'hFFFF_FFFC));
        run_op(-32'sd8, -32'sd4, 32'd0, 8'hF8, 8'hFC, 8'd0, 1'b0, "neg8");
        chk("neg8.x_const", 64'(x32), 64'(32'hFFFF_FFF0));
        chk("neg8.z_const", 64'(z32), 64'(32'hFFFF_FFF8));
        run_op(32'd1, 32'd2, 32'd3, 8'hC8, 8'h64, 8'h00, 1'b0, "w8");
        chk("w8.x8u_const", 64'(x8u), 64'd144);
        chk("w8.z8u_const", 64'(z8u), 64'd200);
        chk("w8.x8s_const", 64'(x8s), 64'd44);
        chk("w8.z8s_const", 64'(z8s), 64'd44);

        // Second Start while busy must be ignored.
        run_op(32'd5, 32'd3, 32'd10, 8'd7, 8'd1, 8'd9, 1'b1, "retrig");
        chk("retrig.x_const", 64'(x32), 64'd30);

        // Reset in the middle of an operation.
        @(negedge clk);
        a32 = 32'd9; b32 = 32'd1; c32 = 32'd2; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort.busy", 64'(busy32), 64'd0);
        chk("abort.done", 64'(done32), 64'd0);
        chk("abort.x", 64'(x32), 64'd0);
        chk("abort.z", 64'(z32), 64'd0);
        dones = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (done32) dones++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (done32) dones++;
        end
        chk("abort.no_done", 64'(dones), 64'd0);
        chk("abort.x_held", 64'(x32), 64'd0);
        run_op(32'd4, 32'd2, 32'd2, 8'd4, 8'd2, 8'd2, 1'b0, "after_abort");

        // Randomized operands, some forced to make d == e.
        for (int i = 0; i < 30; i++) begin
            ra = $urandom; rb = $urandom; rc = $urandom;
            if (i % 4 == 0) rc = rb;
            run_op(ra, rb, rc, ra[7:0], rb[7:0], rc[15:8] & ((i % 4 == 0) ? 8'h00 : 8'hFF) | ((i % 4 == 0) ? rb[7:0] : 8'h00),
                   1'b0, $sformatf("rand%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
